// File: rtl/icache_refill_if.sv
// icache_refill_if: fetch-side lookup and memory refill signals of the instruction cache.
interface icache_refill_if;
    logic [63:0] PC;
    logic        FE_REQ;
    logic        FLUSH;
    logic        cache_hit;
    logic [31:0] instruction;
    logic        cache_err;
    logic        MEM_REQ;
    logic [63:0] MEM_ADDR;
    logic        MEM_RDY;
    logic        MEM_RVALID;
    logic [31:0] MEM_RDATA;
    logic        MEM_ERR;
    modport slave (
        input  PC, FE_REQ, FLUSH, MEM_RDY, MEM_RVALID, MEM_RDATA, MEM_ERR,
        output cache_hit, instruction, cache_err, MEM_REQ, MEM_ADDR
    );
    modport master (
        output PC, FE_REQ, FLUSH, MEM_RDY, MEM_RVALID, MEM_RDATA, MEM_ERR,
        input  cache_hit, instruction, cache_err, MEM_REQ, MEM_ADDR
    );
endinterface

// File: rtl/icache_refill.sv
// icache_refill: direct-mapped instruction cache with a beat-based line refill FSM.
// Defining ICACHE_PERF_CNT_EN adds hit_count/miss_count outputs.
module icache_refill #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic CLK,
    input  logic RESET,
    icache_refill_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [63:0] hit_count,
    output logic [63:0] miss_count
`endif
);
    localparam int IB = $clog2(NUM_LINES);
    localparam int WB = $clog2(LINE_WORDS);
    localparam int OB = WB + 2;
    localparam int TB = 64 - OB - IB;
    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
    state_t r_state, w_next;
    logic [NUM_LINES-1:0] r_valid;
    logic [TB-1:0] r_tag [NUM_LINES];
    logic [31:0] r_data [NUM_LINES][LINE_WORDS];
    logic r_req, r_kill, r_fault, r_err_v;
    logic [63:0] r_addr, r_err_addr;
    logic [IB-1:0] r_idx;
    logic [WB-1:0] r_beat;
    logic [IB-1:0] w_index;
    logic [WB-1:0] w_word;
    logic [TB-1:0] w_tag;
    logic [63:0] w_line;
    logic w_hit, w_err, w_start, w_accept, w_beat, w_last, w_bad;
    assign w_word   = bus.PC[OB-1:2];
    assign w_index  = bus.PC[OB+IB-1:OB];
    assign w_tag    = bus.PC[63:OB+IB];
    assign w_line   = {bus.PC[63:OB], {OB{1'b0}}};
    assign w_hit    = r_state == IDLE && r_valid[w_index] && r_tag[w_index] == w_tag;
    assign w_err    = r_state == IDLE && r_err_v && w_line == r_err_addr;
    assign w_start  = r_state == IDLE && bus.FE_REQ && !w_hit && !bus.FLUSH && !w_err;
    assign w_accept = r_state == REQ && r_req && bus.MEM_RDY;
    assign w_beat   = r_state == FILL && bus.MEM_RVALID;
    assign w_last   = w_beat && r_beat == WB'(LINE_WORDS - 1);
    assign w_bad    = r_fault || bus.MEM_ERR;
    assign bus.cache_hit   = w_hit;
    assign bus.instruction = r_data[w_index][w_word];
    assign bus.cache_err   = w_err;
    assign bus.MEM_REQ     = r_req;
    assign bus.MEM_ADDR    = r_addr;
    always_comb begin
        w_next = r_state;
        w_next = w_start ? REQ : w_accept ? FILL : w_last ? IDLE : r_state;
    end
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state    <= IDLE;
            r_valid    <= '0;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_idx      <= '0;
            r_beat     <= '0;
            r_err_v    <= 1'b0;
            r_err_addr <= '0;
            r_kill     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_next;
            // The line being refilled is invalid until its last beat lands cleanly.
            if (w_start) begin
                r_req            <= 1'b1;
                r_addr           <= w_line;
                r_idx            <= w_index;
                r_valid[w_index] <= 1'b0;
                r_err_v          <= 1'b0;
                r_kill           <= 1'b0;
                r_fault          <= 1'b0;
            end
            if (w_accept) begin
                r_req  <= 1'b0;
                r_beat <= '0;
            end
            if (w_beat) begin
                r_beat  <= r_beat + WB'(1);
                r_fault <= w_bad;
            end
            if (w_last && !w_bad && !r_kill) r_valid[r_idx] <= 1'b1;
            if (w_last && w_bad) begin
                r_err_v    <= 1'b1;
                r_err_addr <= r_addr;
            end
            // Placed last so a flush overrides a same-cycle final beat.
            if (bus.FLUSH) begin
                r_valid <= '0;
                r_err_v <= 1'b0;
                r_kill  <= r_state != IDLE;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RESET && w_beat) r_data[r_idx][r_beat] <= bus.MEM_RDATA;
        if (RESET && w_last) r_tag[r_idx] <= r_addr[63:OB+IB];
    end
`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (bus.FE_REQ && w_hit) hit_count <= hit_count + 64'd1;
            if (w_start) miss_count <= miss_count + 64'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed scenario tests for icache_refill with hand-computed expectations.
module tb_icache_refill;
    logic CLK;
    logic RESET;
    int n_vec = 0;
    int n_err = 0;
    icache_refill_if bus();
    icache_refill dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic beats(input logic [31:0] base, input logic [31:0] step,
                         input logic [3:0] err_mask, input logic [3:0] flush_mask);
        for (int i = 0; i < 4; i++) begin
            bus.MEM_RVALID = 1'b1;
            bus.MEM_RDATA  = base + 32'(i) * step;
            bus.MEM_ERR    = err_mask[i];
            bus.FLUSH      = flush_mask[i];
            tick();
        end
        bus.MEM_RVALID = 1'b0;
        bus.MEM_ERR    = 1'b0;
        bus.FLUSH      = 1'b0;
    endtask

    task automatic test_reset();
        bus.PC = '0; bus.FE_REQ = 0; bus.FLUSH = 0; bus.MEM_RDY = 0;
        bus.MEM_RVALID = 0; bus.MEM_RDATA = '0; bus.MEM_ERR = 0;
        RESET = 1'b0;
        tick(); tick();
        n_vec++; if (bus.MEM_REQ !== 1'b0) begin n_err++; $display("FAIL reset_memreq got=%b exp=0", bus.MEM_REQ); end
        n_vec++; if (bus.MEM_ADDR !== 64'h0) begin n_err++; $display("FAIL reset_memaddr got=%h exp=0", bus.MEM_ADDR); end
        n_vec++; if (bus.cache_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit got=%b exp=0", bus.cache_hit); end
        n_vec++; if (bus.cache_err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", bus.cache_err); end
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_cold_miss();
        bus.PC = 64'h1000; bus.FE_REQ = 1; bus.MEM_RDY = 1;
        #1;
        n_vec++; if (bus.cache_hit !== 1'b0) begin n_err++; $display("FAIL cold_c0_hit got=%b exp=0", bus.cache_hit); end
        n_vec++; if (bus.MEM_REQ !== 1'b0) begin n_err++; $display("FAIL cold_c0_req got=%b exp=0", bus.MEM_REQ); end
        tick();
        n_vec++; if (bus.MEM_REQ !== 1'b1) begin n_err++; $display("FAIL cold_c1_req got=%b exp=1", bus.MEM_REQ); end
        n_vec++; if (bus.MEM_ADDR !== 64'h1000) begin n_err++; $display("FAIL cold_c1_addr got=%h exp=1000", bus.MEM_ADDR); end
        tick();
        n_vec++; if (bus.MEM_REQ !== 1'b0) begin n_err++; $display("FAIL cold_c2_req got=%b exp=0", bus.MEM_REQ); end
        n_vec++; if (bus.cache_hit !== 1'b0) begin n_err++; $display("FAIL cold_c2_hit got=%b exp=0", bus.cache_hit); end
        beats(32'h11, 32'h11, 4'b0000, 4'b0000);
        #1;
        n_vec++; if (bus.cache_hit !== 1'b1) begin n_err++; $display("FAIL cold_c6_hit got=%b exp=1", bus.cache_hit); end
        n_vec++; if (bus.instruction !== 32'h11) begin n_err++; $display("FAIL cold_w0 got=%h exp=11", bus.instruction); end
        bus.PC = 64'h1008;
        #1;
        n_vec++; if (bus.instruction !== 32'h33 || bus.cache_hit !== 1'b1) begin n_err++; $display("FAIL cold_w2 got=%h/%b exp=33/1", bus.instruction, bus.cache_hit); end
        bus.PC = 64'h100C;
        #1;
        n_vec++; if (bus.instruction !== 32'h44) begin n_err++; $display("FAIL cold_w3 got=%h exp=44", bus.instruction); end
    endtask

    task automatic test_conflict();
        bus.PC = 64'h1400; bus.FE_REQ = 1;
        #1;
        n_vec++; if (bus.cache_hit !== 1'b0) begin n_err++; $display("FAIL conf_hit got=%b exp=0", bus.cache_hit); end
        tick();
        n_vec++; if (bus.MEM_REQ !== 1'b1 || bus.MEM_ADDR !== 64'h1400) begin n_err++; $display("FAIL conf_req got=%b/%h exp=1/1400", bus.MEM_REQ, bus.MEM_ADDR); end
        tick();
        beats(32'hA1, 32'h1, 4'b0000, 4'b0000);
        #1;
        n_vec++; if (bus.cache_hit !== 1'b1 || bus.instruction !== 32'hA1) begin n_err++; $display("FAIL conf_fill got=%b/%h exp=1/a1", bus.cache_hit, bus.instruction); end
        bus.FE_REQ = 0; bus.PC = 64'h1000;
        #1;
        n_vec++; if (bus.cache_hit !== 1'b0) begin n_err++; $display("FAIL conf_evict got=%b exp=0", bus.cache_hit); end
        tick();
    endtask

    task automatic test_stall();
        bus.PC = 64'h2000; bus.FE_REQ = 1; bus.MEM_RDY = 0;
        #1;
        tick();
        bus.FE_REQ = 0;
        for (int i = 0; i < 3; i++) begin
            bus.MEM_RVALID = 1; bus.MEM_RDATA = 32'hDEAD0000 + 32'(i);
            #1;
            n_vec++; if (bus.MEM_REQ !== 1'b1 || bus.MEM_ADDR !== 64'h2000) begin n_err++; $display("FAIL stall_hold%0d got=%b/%h exp=1/2000", i, bus.MEM_REQ, bus.MEM_ADDR); end
            tick();
        end
        bus.MEM_RVALID = 0; bus.MEM_RDY = 1;
        #1;
        n_vec++; if (bus.MEM_REQ !== 1'b1) begin n_err++; $display("FAIL stall_accept got=%b exp=1", bus.MEM_REQ); end
        tick();
        n_vec++; if (bus.MEM_REQ !== 1'b0) begin n_err++; $display("FAIL stall_drop got=%b exp=0", bus.MEM_REQ); end
        beats(32'hB0, 32'h1, 4'b0000, 4'b0000);
        #1;
        n_vec++; if (bus.cache_hit !== 1'b1 || bus.instruction !== 32'hB0) begin n_err++; $display("FAIL stall_w0 got=%b/%h exp=1/b0", bus.cache_hit, bus.instruction); end
        bus.PC = 64'h200C;
        #1;
        n_vec++; if (bus.instruction !== 32'hB3) begin n_err++; $display("FAIL stall_w3 got=%h exp=b3", bus.instruction); end
    endtask

    task automatic test_bus_error();
        bus.PC = 64'h1000; bus.FE_REQ = 1; bus.MEM_RDY = 1;
        #1;
        tick(); tick();
        beats(32'hE0, 32'h1, 4'b0100, 4'b0000);
        #1;
        n_vec++; if (bus.cache_hit !== 1'b0) begin n_err++; $display("FAIL berr_hit got=%b exp=0", bus.cache_hit); end
        n_vec++; if (bus.cache_err !== 1'b1) begin n_err++; $display("FAIL berr_err got=%b exp=1", bus.cache_err); end
        tick();
        n_vec++; if (bus.MEM_REQ !== 1'b0 || bus.cache_err !== 1'b1) begin n_err++; $display("FAIL berr_norereq got=%b/%b exp=0/1", bus.MEM_REQ, bus.cache_err); end
        bus.FE_REQ = 0; bus.PC = 64'h2000;
        #1;
        n_vec++; if (bus.cache_hit !== 1'b0 || bus.cache_err !== 1'b0) begin n_err++; $display("FAIL berr_victim got=%b/%b exp=0/0", bus.cache_hit, bus.cache_err); end
        bus.PC = 64'h1000; bus.FE_REQ = 1; bus.FLUSH = 1;
        tick();
        bus.FLUSH = 0;
        #1;
        n_vec++; if (bus.cache_err !== 1'b0) begin n_err++; $display("FAIL berr_flush got=%b exp=0", bus.cache_err); end
        tick();
        n_vec++; if (bus.MEM_REQ !== 1'b1 || bus.MEM_ADDR !== 64'h1000) begin n_err++; $display("FAIL berr_retry got=%b/%h exp=1/1000", bus.MEM_REQ, bus.MEM_ADDR); end
        tick();
        beats(32'hC0, 32'h1, 4'b0000, 4'b0000);
        #1;
        n_vec++; if (bus.cache_hit !== 1'b1 || bus.instruction !== 32'hC0) begin n_err++; $display("FAIL berr_refill got=%b/%h exp=1/c0", bus.cache_hit, bus.instruction); end
    endtask

    task automatic test_flush_mid_fill();
        bus.PC = 64'h3000; bus.FE_REQ = 1;
        #1;
        tick(); tick();
        beats(32'hD0, 32'h1, 4'b0000, 4'b0010);
        #1;
        n_vec++; if (bus.cache_hit !== 1'b0) begin n_err++; $display("FAIL fmid_hit got=%b exp=0", bus.cache_hit); end
        tick();
        n_vec++; if (bus.MEM_REQ !== 1'b1 || bus.MEM_ADDR !== 64'h3000) begin n_err++; $display("FAIL fmid_rereq got=%b/%h exp=1/3000", bus.MEM_REQ, bus.MEM_ADDR); end
        tick();
        beats(32'hE0, 32'h1, 4'b0000, 4'b1000);
        #1;
        n_vec++; if (bus.cache_hit !== 1'b0) begin n_err++; $display("FAIL flast_hit got=%b exp=0", bus.cache_hit); end
        tick();
        n_vec++; if (bus.MEM_REQ !== 1'b1) begin n_err++; $display("FAIL flast_rereq got=%b exp=1", bus.MEM_REQ); end
        tick();
        beats(32'hF0, 32'h1, 4'b0000, 4'b0000);
        #1;
        n_vec++; if (bus.cache_hit !== 1'b1 || bus.instruction !== 32'hF0) begin n_err++; $display("FAIL fmid_final got=%b/%h exp=1/f0", bus.cache_hit, bus.instruction); end
    endtask

    task automatic test_reset_mid_fill();
        bus.PC = 64'h4000; bus.FE_REQ = 1;
        #1;
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            bus.MEM_RVALID = 1; bus.MEM_RDATA = 32'h40 + 32'(i);
            tick();
        end
        bus.MEM_RVALID = 0; bus.FE_REQ = 0; RESET = 0;
        tick();
        RESET = 1;
        #1;
        n_vec++; if (bus.MEM_REQ !== 1'b0 || bus.MEM_ADDR !== 64'h0) begin n_err++; $display("FAIL rmid_req got=%b/%h exp=0/0", bus.MEM_REQ, bus.MEM_ADDR); end
        n_vec++; if (bus.cache_hit !== 1'b0) begin n_err++; $display("FAIL rmid_hit got=%b exp=0", bus.cache_hit); end
        for (int i = 2; i < 4; i++) begin
            bus.MEM_RVALID = 1; bus.MEM_RDATA = 32'hBAD0 + 32'(i);
            tick();
        end
        bus.MEM_RVALID = 0;
        #1;
        n_vec++; if (bus.MEM_REQ !== 1'b0) begin n_err++; $display("FAIL rmid_stray got=%b exp=0", bus.MEM_REQ); end
        bus.PC = 64'h3000;
        #1;
        n_vec++; if (bus.cache_hit !== 1'b0 || bus.cache_err !== 1'b0) begin n_err++; $display("FAIL rmid_old got=%b/%b exp=0/0", bus.cache_hit, bus.cache_err); end
        bus.PC = 64'h4000; bus.FE_REQ = 1;
        #1;
        n_vec++; if (bus.cache_hit !== 1'b0) begin n_err++; $display("FAIL rmid_lookup got=%b exp=0", bus.cache_hit); end
        tick();
        n_vec++; if (bus.MEM_REQ !== 1'b1 || bus.MEM_ADDR !== 64'h4000) begin n_err++; $display("FAIL rmid_miss got=%b/%h exp=1/4000", bus.MEM_REQ, bus.MEM_ADDR); end
        bus.FE_REQ = 0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_stall();
        test_bus_error();
        test_flush_mid_fill();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Instruction-side cache that answers the fetch stage's PC lookup with a hit flag and a 32-bit instruction word.
- It is direct-mapped; every line is a full multi-word block.
- On a miss it runs a refill state machine on a beat-based memory read interface.
- It sits between the fetch stage and the memory arbiter, and supports whole-cache invalidate for FENCE.I.

Parameters:
- NUM_LINES, 64, number of cache lines; power of two. INDEX_BITS = log2(NUM_LINES).
- LINE_WORDS, 4, 32-bit words per line; power of two. OFFSET_BITS = log2(LINE_WORDS) + 2.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous reset, active-low (0 = reset).
- PC  input  64  fetch address. PC[1:0] is ignored; fetch handles misalignment.
- FE_REQ  input  1  fetch wants PC this cycle. Misses only start a refill when this is 1.
- FLUSH  input  1  one-cycle pulse that invalidates all lines.
- cache_hit  output  1  instruction is valid for PC this cycle (combinational).
- instruction  output  32  word selected by PC; undefined (tests may treat it as don't-care) when cache_hit=0.
- cache_err  output  1  the last refill of PC's line faulted.
- MEM_REQ  output  1  line read request (registered).
- MEM_ADDR  output  64  line-aligned address, {tag, index, OFFSET_BITS zeros} (registered).
- MEM_RDY  input  1  memory accepts the request when MEM_REQ && MEM_RDY.
- MEM_RVALID  input  1  one data beat is valid.
- MEM_RDATA  input  32  beat data, delivered in ascending word order.
- MEM_ERR  input  1  beat carries a bus error; sampled only with MEM_RVALID.

Behaviour:
- Address split:
  - word select = PC[OFFSET_BITS-1:2]
  - index = PC[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS]
  - tag = the remaining upper bits
- Storage:
  - valid bit per line (reset to 0)
  - tag array, data array, both combinationally read
- cache_hit = (state==IDLE) && valid[index] && tag match. When it is 1, instruction = data[index][word select].
- States: IDLE, REQ, FILL.
- IDLE:
  - If FE_REQ && !cache_hit && !FLUSH && !(cache_err for this PC): latch line address and index, clear err_v, go to REQ. MEM_REQ=1 and MEM_ADDR are valid on the next cycle.
  - Otherwise stay in IDLE.
- REQ:
  - MEM_REQ and MEM_ADDR are held stable until MEM_REQ && MEM_RDY.
  - On that cycle: MEM_REQ drops next cycle, beat counter is set to 0, go to FILL.
- FILL:
  - Each MEM_RVALID writes MEM_RDATA into data[latched index][beat] and increments the beat counter.
  - Any beat with MEM_ERR=1 sets a fault flag.
  - On beat LINE_WORDS-1, return to IDLE.
    - If there was no fault and no kill: write the tag and set valid[latched index].
    - If there was a fault: line stays invalid, err_v=1, err_addr=latched line address.
- cache_err = err_v && (PC line address == err_addr) && state==IDLE.
  - Blocks re-request of that line until FLUSH or a miss on a different line.
  - err_v is cleared by FLUSH or when a new refill starts.
- Hit-after-fill: first cache_hit for the refilled line is the cycle after the final beat.
- Miss latency with MEM_RDY tied to 1 and back-to-back beats: miss at cycle 0, MEM_REQ at 1, beats at 2..5, hit at 6.
- PC changes during REQ/FILL: the in-flight refill finishes for the original line. cache_hit stays 0 until IDLE, then the new PC is looked up.
- FLUSH:
  - In any state, clears all valid bits and err_v on the next edge.
  - If it arrives during REQ/FILL, a kill flag is set: the refill still consumes all beats, but the line is not validated.
  - FLUSH and the final beat on the same cycle: flush wins, line invalid.
- MEM_RVALID in IDLE or REQ is ignored.
- Reset (RESET=0), including mid-refill:
  - state=IDLE, all valid=0, MEM_REQ=0, MEM_ADDR=0, beat counter=0, err_v=0, kill=0, fault=0.
  - So cache_hit=0 and cache_err=0.
  - Beats still arriving after reset are ignored.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- When defined, adds outputs hit_count[63:0] and miss_count[63:0].
  - Both reset to 0.
  - hit_count increments on each cycle with FE_REQ && cache_hit.
  - miss_count increments on each IDLE->REQ transition.
  - Both wrap modulo 2^64.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Cold miss: reset, PC=0x1000, FE_REQ=1, MEM_RDY=1, beats 0x11,0x22,0x33,0x44 back-to-back -> MEM_REQ at cycle 1 with MEM_ADDR=0x1000; cache_hit=1 at cycle 6; PC=0x1008 gives instruction=0x33.
- Conflict: after the fill above, PC=0x1400 (same index, different tag) -> cache_hit=0, MEM_ADDR=0x1400. After refill, PC=0x1000 misses again.
- Stalled handshake: MEM_RDY=0 for 3 cycles -> MEM_REQ and MEM_ADDR stay stable; one request accepted; no beats written before acceptance.
- Bus error: beat 2 with MEM_ERR=1 -> line invalid, cache_err=1 for PC=0x1000, no new MEM_REQ; after FLUSH, cache_err=0 and a refill is re-requested.
- Flush mid-fill: FLUSH during beat 1 -> all 4 beats consumed, cache_hit=0 afterward, a new refill starts for the same PC.
- Reset mid-fill: RESET=0 after beat 1 -> MEM_REQ=0, cache_hit=0; stray beats 2-3 are ignored; the next lookup misses.
